mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares the single physical-memory line port (cacheline adaptor side) between the instruction cache and the data cache. It sits below both caches and above the cacheline adaptor, sequencing one full line transaction at a time. It latches the winning request, holds the downstream command stable until the adaptor responds, and routes the response back to the winner only. Round-robin on ties keeps a hot dcache from starving instruction fetch.

## Interface
Parameters:
- ADDR_W, 32, line address width
- LINE_W, 256, cache line width

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset (reset when rst==0 at a rising edge)
- i_read  in  1  icache line-read request, level, held until i_resp
- i_address  in  ADDR_W  icache line address
- i_rdata  out  LINE_W  line data to icache
- i_resp  out  1  icache transaction done, 1-cycle pulse
- d_read  in  1  dcache line-read request, level
- d_write  in  1  dcache line-writeback request, level
- d_address  in  ADDR_W  dcache line address
- d_wdata  in  LINE_W  dcache writeback data
- d_rdata  out  LINE_W  line data to dcache
- d_resp  out  1  dcache transaction done, 1-cycle pulse
- pmem_read  out  1  downstream read command
- pmem_write  out  1  downstream write command
- pmem_address  out  ADDR_W  downstream line address
- pmem_wdata  out  LINE_W  downstream write data
- pmem_rdata  in  LINE_W  downstream read data
- pmem_resp  in  1  downstream transaction done, 1-cycle pulse

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D, RELEASE.
- Register last_grant (I or D); reset value D, so the first tie goes to I.
- IDLE: i_req = i_read; d_req = d_read|d_write.
  - Only i_req: go to SERVE_I.
  - Only d_req: go to SERVE_D.
  - Both: grant the side that is not last_grant.
  - Neither: stay in IDLE.
  - On a grant: latch the address, and for D also the op (write if d_write) and d_wdata, into command registers; update last_grant.
- SERVE_I / SERVE_D:
  - pmem_read/pmem_write/pmem_address/pmem_wdata are driven from the command registers, constant for the whole state.
  - On pmem_resp: assert the winner's resp combinationally in the same cycle, then go to RELEASE.
- RELEASE: one dead cycle with no command and no grant, so the requester can drop its level request. Always go to IDLE.
- Read data routing: i_rdata = d_rdata = pmem_rdata (passthrough). Only the winner's resp qualifies it.
- Loser's resp is 0 at all times. i_resp and d_resp are never both 1.
- d_read and d_write both 1: write takes precedence (a writeback precedes a refill); read remains pending for a later grant.
- Requester deasserts mid-transaction: the transaction still runs to pmem_resp. The adaptor cannot abort. The resp pulse is still generated.
- Inputs changing mid-transaction: ignored, because the command registers hold the values latched at grant.
- pmem_resp outside SERVE_*: ignored, no resp generated, no state change.
- Reset at any time, including mid-transaction: state IDLE, last_grant D, command registers cleared.

## Timing
- Reset values: pmem_read 0, pmem_write 0, pmem_address 0, pmem_wdata 0, i_resp 0, d_resp 0.
- Grant latency: request first seen in IDLE at edge n; pmem command asserted from cycle n+1 (registered).
- Response latency: pmem_resp in cycle m gives the winner's resp in cycle m (0 added). The command drops at m+1 (RELEASE).
- Back-to-back service:
  - IDLE at m+2.
  - Next command at the earliest at m+3.
  - Minimum turnaround is 3 cycles from one pmem_resp to the next command.
- The command is never dropped or changed between its assert and pmem_resp.

## Test plan
- Single icache read at 0x0000_1000; adaptor responds after 5 cycles with line 0xA5…A5 -> pmem_read=1 with address 0x1000 from the cycle after the request; i_resp=1 for exactly 1 cycle with i_rdata=0xA5…A5; d_resp stays 0.
- i_read and d_write requested in the same cycle after reset -> I is served first (last_grant reset = D). D is commanded 3 cycles after I's pmem_resp with pmem_write=1 and the latched wdata.
- Continuous d_read plus continuous i_read for 6 transactions -> grants alternate I, D, I, D, I, D; no side gets two grants in a row.
- d_address changed from 0x2000 to 0x3000 mid-transaction -> pmem_address stays 0x2000 until pmem_resp.
- d_read and d_write both 1 -> pmem_write issued first; the read follows on the next D grant.
- rst=0 for one cycle during SERVE_D -> pmem_read/pmem_write are 0 the next cycle; no d_resp; a fresh request is granted normally afterward.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one cacheline-adaptor port between icache and dcache, one line transaction at a time.
// Latency: command registered 1 cycle after grant; resp combinational with pmem_resp; 3-cycle turnaround.
// Backpressure: requests are level-held until their resp; a loser waits in place with no queueing.
//
// Ports: clk/rst (sync, active-low); icache i_read/i_address -> i_rdata/i_resp;
//        dcache d_read/d_write/d_address/d_wdata -> d_rdata/d_resp;
//        adaptor pmem_read/pmem_write/pmem_address/pmem_wdata <- pmem_rdata/pmem_resp.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                last_i_q, last_i_d;       // 1: icache won the most recent grant
  logic                cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [LINE_W-1:0]   cmd_wdata_q, cmd_wdata_d;

  logic i_req;
  logic d_req;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_i_q    <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_i_q    <= last_i_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_i_d    = last_i_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie the side that did not win last time gets the port.
        if (i_req && (!d_req || !last_i_q)) begin
          state_d     = SERVE_I;
          last_i_d    = 1'b1;
          cmd_write_d = 1'b0;
          cmd_addr_d  = i_address;
        end else if (d_req) begin
          state_d     = SERVE_D;
          last_i_d    = 1'b0;
          // A pending writeback goes before a refill; the read stays pending.
          cmd_write_d = d_write;
          cmd_addr_d  = d_address;
          cmd_wdata_d = d_wdata;
        end
      end
      SERVE_I: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          i_resp  = 1'b1;
          state_d = RELEASE;
        end
      end
      SERVE_D: begin
        pmem_read  = !cmd_write_q;
        pmem_write = cmd_write_q;
        if (pmem_resp) begin
          d_resp  = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Dead cycle so the finished requester can drop its level request.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pmem_address = cmd_addr_q;
  assign pmem_wdata   = cmd_wdata_q;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Samples taken mid-cycle (falling edge).
  logic          s_rd, s_wr, s_ir, s_dr;
  logic [AW-1:0] s_addr;
  logic [LW-1:0] s_wdata, s_irdata, s_drdata;

  // Transaction-level reference: the one line transaction currently owning the port,
  // the first cycle the arbiter is free again, and who won last.
  logic          m_act = 1'b0;
  logic          m_is_i = 1'b0;
  logic          m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0;
  logic          m_last_i = 1'b0;
  int            m_free_at = 0;
  int            cyc = 0;
  logic          model_ok = 1'b0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkl(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle with the currently driven inputs: sample + check, then advance the model.
  task automatic cycle();
    @(negedge clk);
    s_rd = pmem_read;  s_wr = pmem_write;  s_ir = i_resp;  s_dr = d_resp;
    s_addr = pmem_address;  s_wdata = pmem_wdata;  s_irdata = i_rdata;  s_drdata = d_rdata;
    if (model_ok) begin
      chk1("m_pmem_read", s_rd, m_act && !m_wr);
      chk1("m_pmem_write", s_wr, m_act && m_wr);
      chk1("m_i_resp", s_ir, m_act && m_is_i && pmem_resp);
      chk1("m_d_resp", s_dr, m_act && !m_is_i && pmem_resp);
      chk1("m_resp_excl", s_ir && s_dr, 1'b0);
      if (m_act) chka("m_pmem_address", s_addr, m_addr);
      if (m_act && m_wr) chkl("m_pmem_wdata", s_wdata, m_wdata);
      chkl("m_i_rdata", s_irdata, pmem_rdata);
      chkl("m_d_rdata", s_drdata, pmem_rdata);
    end
    @(posedge clk);
    if (!rst) begin
      m_act = 1'b0;  m_last_i = 1'b0;  m_free_at = cyc + 1;
    end else if (m_act) begin
      if (pmem_resp) begin
        m_act = 1'b0;
        m_free_at = cyc + 2;
      end
    end else if (cyc >= m_free_at && (i_read || d_read || d_write)) begin
      m_act  = 1'b1;
      m_is_i = i_read && (!(d_read || d_write) || !m_last_i);
      m_last_i = m_is_i;
      m_wr   = !m_is_i && d_write;
      m_addr = m_is_i ? i_address : d_address;
      if (!m_is_i) m_wdata = d_wdata;
    end
    cyc++;
    model_ok = 1'b1;
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          order [6];
    int            n;
    logic [LW-1:0] wd;
    logic [LW-1:0] a5;

    a5 = {32{8'hA5}};

    // Reset
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk1("rst_pmem_read", s_rd, 1'b0);
    chk1("rst_pmem_write", s_wr, 1'b0);
    chka("rst_pmem_address", s_addr, 32'h0);
    chkl("rst_pmem_wdata", s_wdata, '0);
    chk1("rst_i_resp", s_ir, 1'b0);
    chk1("rst_d_resp", s_dr, 1'b0);

    // Single icache read, adaptor answers after 5 command cycles
    i_read = 1'b1;  i_address = 32'h0000_1000;  pmem_rdata = a5;
    cycle();
    chk1("t1_no_cmd_yet", s_rd, 1'b0);
    cycle();
    chk1("t1_read_cmd", s_rd, 1'b1);
    chka("t1_addr", s_addr, 32'h0000_1000);
    repeat (4) cycle();
    pmem_resp = 1'b1;
    cycle();
    chk1("t1_i_resp", s_ir, 1'b1);
    chkl("t1_i_rdata", s_irdata, a5);
    chk1("t1_d_resp", s_dr, 1'b0);
    pmem_resp = 1'b0;  i_read = 1'b0;
    cycle();
    chk1("t1_i_resp_1cyc", s_ir, 1'b0);
    chk1("t1_cmd_dropped", s_rd, 1'b0);

    // Simultaneous i_read + d_write right after reset: I first, D at resp+3
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    wd = rnd_line();
    i_read = 1'b1;  i_address = 32'h0000_1000;
    d_write = 1'b1; d_address = 32'h0000_4000;  d_wdata = wd;
    cycle();
    cycle();
    chk1("t2_i_first", s_rd, 1'b1);
    chk1("t2_no_write_yet", s_wr, 1'b0);
    pmem_resp = 1'b1;
    cycle();
    chk1("t2_i_resp", s_ir, 1'b1);
    pmem_resp = 1'b0;  i_read = 1'b0;
    cycle();
    chk1("t2_m1_no_cmd", s_wr, 1'b0);
    cycle();
    chk1("t2_m2_no_cmd", s_wr, 1'b0);
    cycle();
    chk1("t2_m3_write", s_wr, 1'b1);
    chkl("t2_m3_wdata", s_wdata, wd);
    chka("t2_m3_addr", s_addr, 32'h0000_4000);
    pmem_resp = 1'b1;
    cycle();
    chk1("t2_d_resp", s_dr, 1'b1);
    chk1("t2_no_i_resp", s_ir, 1'b0);
    pmem_resp = 1'b0;  d_write = 1'b0;
    cycle();

    // Continuous contention: grants alternate starting with I
    i_read = 1'b1;  d_read = 1'b1;  d_address = 32'h0000_8000;
    n = 0;
    for (int k = 0; k < 100 && n < 6; k++) begin
      pmem_resp = (s_rd || s_wr) && !(s_ir || s_dr);
      cycle();
      if (s_ir) begin order[n] = 1'b1; n++; end
      else if (s_dr) begin order[n] = 1'b0; n++; end
    end
    chk1("t3_six_grants", n == 6, 1'b1);
    for (int i = 0; i < 6; i++) chk1("t3_alternate", order[i], (i % 2) == 0);
    pmem_resp = 1'b0;  i_read = 1'b0;  d_read = 1'b0;
    cycle();
    cycle();

    // Address change mid-transaction is ignored
    d_read = 1'b1;  d_address = 32'h0000_2000;
    cycle();
    cycle();
    chk1("t4_read", s_rd, 1'b1);
    chka("t4_addr", s_addr, 32'h0000_2000);
    d_address = 32'h0000_3000;
    repeat (3) begin
      cycle();
      chka("t4_addr_held", s_addr, 32'h0000_2000);
    end
    pmem_resp = 1'b1;
    cycle();
    chk1("t4_d_resp", s_dr, 1'b1);
    pmem_resp = 1'b0;  d_read = 1'b0;
    cycle();
    cycle();

    // Read + write together: write first, read on the next D grant
    wd = rnd_line();
    d_read = 1'b1;  d_write = 1'b1;  d_address = 32'h0000_5000;  d_wdata = wd;
    cycle();
    cycle();
    chk1("t5_write_first", s_wr, 1'b1);
    chk1("t5_no_read", s_rd, 1'b0);
    pmem_resp = 1'b1;
    cycle();
    pmem_resp = 1'b0;  d_write = 1'b0;
    cycle();
    cycle();
    cycle();
    chk1("t5_read_follows", s_rd, 1'b1);
    chk1("t5_read_not_write", s_wr, 1'b0);
    pmem_resp = 1'b1;
    cycle();
    chk1("t5_d_resp", s_dr, 1'b1);
    pmem_resp = 1'b0;  d_read = 1'b0;
    cycle();
    cycle();

    // Reset during SERVE_D, then a fresh request
    d_read = 1'b1;  d_address = 32'h0000_6000;
    cycle();
    cycle();
    chk1("t6_serving", s_rd, 1'b1);
    rst = 1'b0;
    cycle();
    rst = 1'b1;  d_read = 1'b0;  pmem_resp = 1'b1;
    cycle();
    chk1("t6_read_cleared", s_rd, 1'b0);
    chk1("t6_write_cleared", s_wr, 1'b0);
    chk1("t6_no_d_resp", s_dr, 1'b0);
    pmem_resp = 1'b0;  i_read = 1'b1;  i_address = 32'h0000_7000;
    cycle();
    cycle();
    chk1("t6_fresh_grant", s_rd, 1'b1);
    chka("t6_fresh_addr", s_addr, 32'h0000_7000);
    pmem_resp = 1'b1;
    cycle();
    chk1("t6_i_resp", s_ir, 1'b1);
    pmem_resp = 1'b0;  i_read = 1'b0;
    cycle();

    // Randomized traffic against the reference
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 5) == 0) i_read = ~i_read;
      if ($urandom_range(0, 5) == 0) d_read = ~d_read;
      if ($urandom_range(0, 7) == 0) d_write = ~d_write;
      if ($urandom_range(0, 3) == 0) i_address = $urandom;
      if ($urandom_range(0, 3) == 0) d_address = $urandom;
      if ($urandom_range(0, 3) == 0) d_wdata = rnd_line();
      pmem_resp  = ($urandom_range(0, 3) == 0);
      pmem_rdata = rnd_line();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
